// File: rtl/bp_fe_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bp_fe_pc_seq
//  Purpose  : Front-end next-PC sequencer. Chooses the fetch address among
//             redirect / resume / override / BTB / sequential sources and
//             tracks issued fetch PCs through a stages_p-deep pipeline that
//             feeds the FE queue writer.
//  Revision : 1.0 - initial release
// ============================================================================
module bp_fe_pc_seq #(
    parameter int                         vaddr_width_p = 39,
    parameter int                         fetch_bytes_p = 4,
    parameter int                         stages_p      = 2,
    parameter logic [vaddr_width_p-1:0]   boot_pc_p     = vaddr_width_p'(39'h0080000000)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      redirect_v_i,
    input  logic [vaddr_width_p-1:0]  redirect_pc_i,
    input  logic                      pred_v_i,
    input  logic [vaddr_width_p-1:0]  pred_pc_i,
    input  logic                      ovr_v_i,
    input  logic [vaddr_width_p-1:0]  ovr_pc_i,
    input  logic                      exc_i,
    input  logic                      hold_i,
    input  logic                      replay_i,
    output logic                      fetch_v_o,
    output logic [vaddr_width_p-1:0]  fetch_pc_o,
    input  logic                      fetch_yumi_i,
    output logic                      poison_o,
    output logic                      pc_v_o,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [1:0]                state_o
);

    localparam int                       c_last        = stages_p - 1;
    localparam logic [vaddr_width_p-1:0] c_one         = vaddr_width_p'(1);
    localparam logic [vaddr_width_p-1:0] c_fetch_bytes = vaddr_width_p'(fetch_bytes_p);
    localparam logic [vaddr_width_p-1:0] c_align_mask  = ~(c_fetch_bytes - c_one);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    state_e                     r_state;
    logic [vaddr_width_p-1:0]   r_resume_pc;
    logic [vaddr_width_p-1:0]   r_stage_pc [stages_p];
    logic                       r_stage_v  [stages_p];

    logic                       w_last_v;
    logic [vaddr_width_p-1:0]   w_last_pc;
    logic [vaddr_width_p-1:0]   w_seq_pc;
    logic                       w_fetch_v;
    logic [vaddr_width_p-1:0]   w_fetch_pc;
    logic                       w_kill_all;

    assign w_last_v   = r_stage_v[c_last];
    assign w_last_pc  = r_stage_pc[c_last];

    // Next block after stage 0: align down, then step one fetch block (wraps).
    assign w_seq_pc   = (r_stage_pc[0] & c_align_mask) + c_fetch_bytes;

    // Redirect, exception and replay flush every in-flight stage.
    assign w_kill_all = redirect_v_i | exc_i | replay_i;

    assign w_fetch_v  = redirect_v_i |
                        ((r_state != ST_WAIT) & ~hold_i & ~replay_i & ~exc_i);

    // Fetch address source selection, highest priority first.
    always_comb begin
        w_fetch_pc = w_seq_pc;
        if (redirect_v_i) begin
            w_fetch_pc = redirect_pc_i;
        end else if (r_state != ST_RUN) begin
            w_fetch_pc = r_resume_pc;
        end else if (ovr_v_i && w_last_v) begin
            w_fetch_pc = ovr_pc_i;
        end else if (pred_v_i && r_stage_v[0]) begin
            w_fetch_pc = pred_pc_i;
        end
    end

    // Control FSM: wait for a redirect, stall until a fetch is accepted, run.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (redirect_v_i) r_state <= ST_STALL;
                end
                ST_STALL: begin
                    if (w_fetch_v && fetch_yumi_i) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_v_i)  r_state <= ST_RUN;
                    else if (replay_i) r_state <= ST_STALL;
                    else if (exc_i)    r_state <= ST_WAIT;
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    // Resume point: redirect target, or the last-stage PC that must be refetched.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_resume_pc <= boot_pc_p;
        end else if (redirect_v_i) begin
            r_resume_pc <= redirect_pc_i;
        end else if ((replay_i || exc_i) && w_last_v) begin
            r_resume_pc <= w_last_pc;
        end
    end

    // PC tracking pipeline: stage 0 takes the new request, later stages shift.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < stages_p; k++) begin
                r_stage_pc[k] <= '0;
                r_stage_v[k]  <= 1'b0;
            end
        end else begin
            r_stage_pc[0] <= w_fetch_pc;
            r_stage_v[0]  <= w_fetch_v & fetch_yumi_i;
            // Override kills stages 0..last-1, i.e. everything shifting into stage k>=1.
            for (int k = 1; k < stages_p; k++) begin
                r_stage_pc[k] <= r_stage_pc[k-1];
                r_stage_v[k]  <= r_stage_v[k-1] & ~w_kill_all & ~ovr_v_i;
            end
        end
    end

    assign fetch_v_o  = w_fetch_v;
    assign fetch_pc_o = w_fetch_pc;
    assign poison_o   = r_stage_v[0] & (w_kill_all | ovr_v_i);
    assign pc_v_o     = w_last_v;
    assign pc_o       = w_last_pc;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_fe_pc_seq
//  Purpose  : Directed self-checking bench for bp_fe_pc_seq (stages_p=2,
//             fetch_bytes_p=8). Expected outputs for each cycle are pushed to
//             a scoreboard queue and popped when the DUT outputs settle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_fe_pc_seq;

    localparam int c_w = 39;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic            redirect_v_i;
    logic [c_w-1:0]  redirect_pc_i;
    logic            pred_v_i;
    logic [c_w-1:0]  pred_pc_i;
    logic            ovr_v_i;
    logic [c_w-1:0]  ovr_pc_i;
    logic            exc_i;
    logic            hold_i;
    logic            replay_i;
    logic            fetch_v_o;
    logic [c_w-1:0]  fetch_pc_o;
    logic            fetch_yumi_i;
    logic            poison_o;
    logic            pc_v_o;
    logic [c_w-1:0]  pc_o;
    logic [1:0]      state_o;

    typedef struct {
        logic            fv;
        logic [c_w-1:0]  fpc;
        logic            poison;
        logic            pcv;
        logic [c_w-1:0]  pc;
        logic [1:0]      st;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_step = 0;

    bp_fe_pc_seq #(
        .vaddr_width_p (c_w),
        .fetch_bytes_p (8),
        .stages_p      (2),
        .boot_pc_p     (39'h0080000000)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .redirect_v_i  (redirect_v_i),
        .redirect_pc_i (redirect_pc_i),
        .pred_v_i      (pred_v_i),
        .pred_pc_i     (pred_pc_i),
        .ovr_v_i       (ovr_v_i),
        .ovr_pc_i      (ovr_pc_i),
        .exc_i         (exc_i),
        .hold_i        (hold_i),
        .replay_i      (replay_i),
        .fetch_v_o     (fetch_v_o),
        .fetch_pc_o    (fetch_pc_o),
        .fetch_yumi_i  (fetch_yumi_i),
        .poison_o      (poison_o),
        .pc_v_o        (pc_v_o),
        .pc_o          (pc_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", tag, n_step, act, exp);
        end
    endtask

    // One cycle: drive inputs just after negedge, queue expectations, check
    // settled outputs 1ns later, then advance through the next posedge.
    task automatic cy(
        input logic rv, input logic [c_w-1:0] rpc,
        input logic pv, input logic [c_w-1:0] ppc,
        input logic ov, input logic [c_w-1:0] opc,
        input logic ex, input logic hd, input logic rp, input logic ym,
        input logic efv, input logic [c_w-1:0] efpc, input logic epo,
        input logic epcv, input logic [c_w-1:0] epc, input logic [1:0] est);
        exp_t e;
        redirect_v_i = rv;  redirect_pc_i = rpc;
        pred_v_i     = pv;  pred_pc_i     = ppc;
        ovr_v_i      = ov;  ovr_pc_i      = opc;
        exc_i        = ex;  hold_i        = hd;
        replay_i     = rp;  fetch_yumi_i  = ym;
        e.fv = efv; e.fpc = efpc; e.poison = epo; e.pcv = epcv; e.pc = epc; e.st = est;
        sb_q.push_back(e);
        n_step++;
        #1;
        e = sb_q.pop_front();
        chk_eq("fetch_v",  64'(fetch_v_o),  64'(e.fv));
        chk_eq("fetch_pc", 64'(fetch_pc_o), 64'(e.fpc));
        chk_eq("poison",   64'(poison_o),   64'(e.poison));
        chk_eq("pc_v",     64'(pc_v_o),     64'(e.pcv));
        chk_eq("pc",       64'(pc_o),       64'(e.pc));
        chk_eq("state",    64'(state_o),    64'(e.st));
        @(negedge clk_i);
    endtask

    initial begin
        reset_n_i = 1'b0;
        redirect_v_i = 1'b0; redirect_pc_i = '0; pred_v_i = 1'b0; pred_pc_i = '0;
        ovr_v_i = 1'b0; ovr_pc_i = '0; exc_i = 1'b0; hold_i = 1'b0; replay_i = 1'b0;
        fetch_yumi_i = 1'b0;
        @(negedge clk_i);
        // Reset state
        cy(0,0, 0,0, 0,0, 0,0,0,0,  0,39'h0080000000, 0, 0,39'h0, 2'd0);
        reset_n_i = 1'b1;
        // Boot: wait without redirect, then redirect 0x1000
        cy(0,0, 0,0, 0,0, 0,0,0,1,  0,39'h0080000000, 0, 0,39'h0, 2'd0);
        cy(1,39'h1000, 0,0, 0,0, 0,0,0,1,  1,39'h1000, 0, 0,39'h0, 2'd0);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1000, 0, 0,39'h0080000000, 2'd2);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1008, 0, 1,39'h1000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1010, 0, 1,39'h1000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1018, 0, 1,39'h1008, 2'd1);
        // Replay with last stage 0x1010
        cy(0,0, 0,0, 0,0, 0,0,1,1,  0,39'h1020, 1, 1,39'h1010, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1010, 0, 0,39'h1018, 2'd2);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1018, 0, 0,39'h1020, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1020, 0, 1,39'h1010, 2'd1);
        // Wrap-around and unaligned redirect
        cy(1,39'h7FFFFFFFF8, 0,0, 0,0, 0,0,0,1,  1,39'h7FFFFFFFF8, 1, 1,39'h1018, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h0, 0, 0,39'h1020, 2'd1);
        cy(1,39'h1004, 0,0, 0,0, 0,0,0,1,  1,39'h1004, 1, 1,39'h7FFFFFFFF8, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h1008, 0, 0,39'h0, 2'd1);
        // BTB prediction from stage 0 = 0x2000
        cy(1,39'h2000, 0,0, 0,0, 0,0,0,1,  1,39'h2000, 1, 1,39'h1004, 2'd1);
        cy(0,0, 1,39'h3000, 0,0, 0,0,0,1,  1,39'h3000, 0, 0,39'h1008, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h3008, 0, 1,39'h2000, 2'd1);
        // Override with last stage 0x2000 (pred raised too, must lose)
        cy(1,39'h2000, 0,0, 0,0, 0,0,0,1,  1,39'h2000, 1, 1,39'h3000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h2008, 0, 0,39'h3008, 2'd1);
        cy(0,0, 1,39'h3000, 1,39'h4000, 0,0,0,1,  1,39'h4000, 1, 1,39'h2000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h4008, 0, 0,39'h2008, 2'd1);
        // Hold blocks issue only; dropped accept is not reissued
        cy(0,0, 0,0, 0,0, 0,1,0,1,  0,39'h4010, 0, 1,39'h4000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h4018, 0, 1,39'h4008, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,0,  1,39'h4020, 0, 0,39'h4010, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h4028, 0, 1,39'h4018, 2'd1);
        // Exception at 0x5000, wait until redirect 0x9000
        cy(1,39'h5000, 0,0, 0,0, 0,0,0,1,  1,39'h5000, 1, 0,39'h4020, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h5008, 0, 0,39'h4028, 2'd1);
        cy(0,0, 0,0, 0,0, 1,0,0,1,  0,39'h5010, 1, 1,39'h5000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  0,39'h5000, 0, 0,39'h5008, 2'd0);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  0,39'h5000, 0, 0,39'h5010, 2'd0);
        cy(1,39'h9000, 0,0, 0,0, 0,0,0,1,  1,39'h9000, 0, 0,39'h5000, 2'd0);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h9000, 0, 0,39'h5000, 2'd2);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h9008, 0, 1,39'h9000, 2'd1);
        // Redirect with replay and exception in the same cycle
        cy(1,39'h9000, 0,0, 0,0, 1,0,1,1,  1,39'h9000, 1, 1,39'h9000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h9008, 0, 0,39'h9008, 2'd1);
        // Replay dominates exception
        cy(0,0, 0,0, 0,0, 1,0,1,1,  0,39'h9010, 1, 1,39'h9000, 2'd1);
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h9000, 0, 0,39'h9008, 2'd2);
        // Reset mid-operation
        reset_n_i = 1'b0;
        cy(0,0, 0,0, 0,0, 0,0,0,1,  1,39'h9008, 0, 0,39'h9010, 2'd1);
        reset_n_i = 1'b1;
        cy(0,0, 0,0, 0,0, 0,0,0,1,  0,39'h0080000000, 0, 0,39'h0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
